// File: rtl/stripe_window_buffer.sv
// Column-stripe window buffer: turns a column-major AXI-Stream pixel feed into one
// BLOCK_SIZE-wide horizontal window per row, with zero/replicate edge padding and right-edge flush.
module stripe_window_buffer #(
    parameter int DATA_WIDTH         = 8,
    parameter int CHANNELS           = 3,
    parameter int BLOCK_SIZE         = 3,
    parameter int C_AXIS_TDATA_WIDTH = 32,
    parameter int IMAGE_HEIGHT       = 480,
    localparam int PIX_W             = CHANNELS * DATA_WIDTH,
    localparam int WIN_W             = CHANNELS * BLOCK_SIZE * DATA_WIDTH,
    localparam int ROW_W             = $clog2(IMAGE_HEIGHT)
) (
    input  logic                            aclk,
    input  logic                            aresetn,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic [C_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s_axis_tstrb,
    input  logic                            s_axis_tlast,
    input  logic                            pad_mode,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic [WIN_W-1:0]                m_window,
    output logic [ROW_W-1:0]                m_row,
    output logic                            m_full,
    output logic                            m_last,
    output logic                            tlast_err
);

    localparam int NSLOT  = BLOCK_SIZE - 1;
    localparam int SLOT_W = (NSLOT > 1) ? $clog2(NSLOT) : 1;
    localparam int CNT_W  = $clog2(BLOCK_SIZE);

    typedef enum logic {
        FILL  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [CNT_W-1:0]  col_sat_q, col_sat_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic [SLOT_W-1:0] wr_slot_q, wr_slot_d;
    logic              pad_mode_q, pad_mode_d;
    logic              tlast_err_q, tlast_err_d;

    logic              m_valid_q;
    logic [WIN_W-1:0]  m_window_q;
    logic [ROW_W-1:0]  m_row_q;
    logic              m_full_q;
    logic              m_last_q;

    // Previous columns, addressed circularly by wr_slot; nothing is ever shifted.
    logic [PIX_W-1:0]  mem_q [NSLOT][IMAGE_HEIGHT];

    logic              out_free;
    logic              accept;
    logic              produce;
    logic              row_last;
    logic              first_pix;
    logic              mode_eff;
    logic              last_win;
    logic              full_win;
    logic [SLOT_W-1:0] prev_slot;
    logic [PIX_W-1:0]  in_col;
    logic [PIX_W-1:0]  pad_col;
    logic [PIX_W-1:0]  new_col;
    logic [PIX_W-1:0]  miss_col;
    logic [WIN_W-1:0]  win_d;

    logic unused_inputs;
    assign unused_inputs = ^{s_axis_tstrb, s_axis_tdata};

    // ---------------------------------------------------------------- state register
    // NOTE: every clocked assignment is non-blocking so all registers update from
    // the same pre-edge values regardless of statement order.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= FILL;
            row_q       <= '0;
            col_sat_q   <= '0;
            flush_cnt_q <= '0;
            wr_slot_q   <= '0;
            pad_mode_q  <= 1'b0;
            tlast_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_sat_q   <= col_sat_d;
            flush_cnt_q <= flush_cnt_d;
            wr_slot_q   <= wr_slot_d;
            pad_mode_q  <= pad_mode_d;
            tlast_err_q <= tlast_err_d;
        end
    end

    // ---------------------------------------------------------------- next state
    // NOTE: every combinational output gets a default before any branch so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_sat_d   = col_sat_q;
        flush_cnt_d = flush_cnt_q;
        wr_slot_d   = wr_slot_q;
        pad_mode_d  = pad_mode_q;
        tlast_err_d = tlast_err_q;

        if (accept && first_pix) pad_mode_d = pad_mode;
        if (accept && s_axis_tlast && !row_last) tlast_err_d = 1'b1;

        if (produce) begin
            row_d = row_last ? '0 : row_q + 1'b1;
            if (row_last) begin
                wr_slot_d = (wr_slot_q == SLOT_W'(NSLOT - 1)) ? '0 : wr_slot_q + 1'b1;
                if (col_sat_q != CNT_W'(NSLOT)) col_sat_d = col_sat_q + 1'b1;
            end
            case (state_q)
                FILL: begin
                    if (s_axis_tlast && row_last) begin
                        state_d     = FLUSH;
                        flush_cnt_d = CNT_W'(1);
                    end
                end
                FLUSH: begin
                    if (row_last) begin
                        if (flush_cnt_q == CNT_W'(NSLOT)) begin
                            state_d     = FILL;
                            col_sat_d   = '0;
                            wr_slot_d   = '0;
                            flush_cnt_d = '0;
                        end else begin
                            flush_cnt_d = flush_cnt_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------------------------------------------------------- FSM outputs
    always_comb begin
        out_free      = !m_valid_q || m_ready;
        s_axis_tready = (state_q == FILL) && out_free;
        accept        = s_axis_tvalid && s_axis_tready;
        produce       = accept || ((state_q == FLUSH) && out_free);
    end

    assign row_last  = (row_q == ROW_W'(IMAGE_HEIGHT - 1));
    assign first_pix = (state_q == FILL) && (col_sat_q == '0) && (row_q == '0);
    // The very first pixel of an image uses the live pad_mode, since it is latched on that same edge.
    assign mode_eff  = first_pix ? pad_mode : pad_mode_q;
    assign last_win  = (state_q == FLUSH) && (flush_cnt_q == CNT_W'(NSLOT)) && row_last;
    assign full_win  = (state_q == FILL) && (col_sat_q == CNT_W'(NSLOT));
    assign prev_slot = (wr_slot_q == '0) ? SLOT_W'(NSLOT - 1) : wr_slot_q - 1'b1;

    always_comb begin
        in_col = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            in_col[c*DATA_WIDTH +: DATA_WIDTH] =
                s_axis_tdata[C_AXIS_TDATA_WIDTH-1-c*DATA_WIDTH -: DATA_WIDTH];
        end
    end

    // ---------------------------------------------------------------- window build
    always_comb begin
        logic [PIX_W-1:0]  col;
        logic [SLOT_W-1:0] slot;
        int                age;

        pad_col  = mode_eff ? mem_q[prev_slot][row_q] : '0;
        new_col  = (state_q == FLUSH) ? pad_col : in_col;
        miss_col = '0;
        // Column 0 still sits in slot 0 whenever any left column is missing.
        if (mode_eff) miss_col = (col_sat_q == '0) ? in_col : mem_q[0][row_q];

        win_d = '0;
        col   = '0;
        slot  = '0;
        for (int j = 0; j < BLOCK_SIZE; j++) begin
            age  = BLOCK_SIZE - 1 - j;
            slot = SLOT_W'((int'(wr_slot_q) + NSLOT - age) % NSLOT);
            if (age == 0)                   col = new_col;
            else if (age > int'(col_sat_q)) col = miss_col;
            else                            col = mem_q[slot][row_q];
            for (int c = 0; c < CHANNELS; c++) begin
                win_d[(c*BLOCK_SIZE+j)*DATA_WIDTH +: DATA_WIDTH] = col[c*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // ---------------------------------------------------------------- column storage
    // NOTE: the column store has no reset; every location is written before it is
    // read within an image, so clearing it would only cost reset fan-out.
    always_ff @(posedge aclk) begin
        if (produce) mem_q[wr_slot_q][row_q] <= new_col;
    end

    // ---------------------------------------------------------------- output register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_valid_q  <= 1'b0;
            m_window_q <= '0;
            m_row_q    <= '0;
            m_full_q   <= 1'b0;
            m_last_q   <= 1'b0;
        end else begin
            if (out_free) m_valid_q <= produce;
            if (produce) begin
                m_window_q <= win_d;
                m_row_q    <= row_q;
                m_full_q   <= full_win;
                m_last_q   <= last_win;
            end
        end
    end

    assign m_valid   = m_valid_q;
    assign m_window  = m_window_q;
    assign m_row     = m_row_q;
    assign m_full    = m_full_q;
    assign m_last    = m_last_q;
    assign tlast_err = tlast_err_q;

endmodule

// File: tb/tb_stripe_window_buffer.sv
// Self-checking bench for stripe_window_buffer: column-indexed reference model with
// directed images plus literal pins on selected windows.
`timescale 1ns/1ps
module tb_stripe_window_buffer;

    localparam int DW    = 8;
    localparam int CH    = 3;
    localparam int BS    = 3;
    localparam int TW    = 32;
    localparam int H     = 4;
    localparam int NS    = BS - 1;
    localparam int WIN_W = CH * BS * DW;
    localparam int ROW_W = $clog2(H);

    logic              aclk = 1'b0;
    logic              aresetn = 1'b0;
    logic              s_axis_tvalid = 1'b0;
    logic              s_axis_tready;
    logic [TW-1:0]     s_axis_tdata = '0;
    logic [TW/8-1:0]   s_axis_tstrb = '1;
    logic              s_axis_tlast = 1'b0;
    logic              pad_mode = 1'b0;
    logic              m_valid;
    logic              m_ready = 1'b1;
    logic [WIN_W-1:0]  m_window;
    logic [ROW_W-1:0]  m_row;
    logic              m_full;
    logic              m_last;
    logic              tlast_err;

    stripe_window_buffer #(
        .DATA_WIDTH(DW), .CHANNELS(CH), .BLOCK_SIZE(BS),
        .C_AXIS_TDATA_WIDTH(TW), .IMAGE_HEIGHT(H)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tstrb(s_axis_tstrb), .s_axis_tlast(s_axis_tlast),
        .pad_mode(pad_mode),
        .m_valid(m_valid), .m_ready(m_ready), .m_window(m_window), .m_row(m_row),
        .m_full(m_full), .m_last(m_last), .tlast_err(tlast_err)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [WIN_W-1:0] win;
        logic [ROW_W-1:0] row;
        logic             full;
        logic             last;
    } exp_t;

    exp_t             exp_q[$];
    logic [WIN_W-1:0] got_win[$];
    logic             got_full[$];
    logic             got_last[$];
    int               dut_cnt = 0;
    int               checks  = 0;
    int               errors  = 0;

    logic [WIN_W-1:0] h_win;
    logic [ROW_W-1:0] h_row;
    int               st, st2;

    task automatic check(input string name, input logic [WIN_W-1:0] act, input logic [WIN_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] samp(int c, int col, int r);
        return 8'((c << 6) + (col << 4) + r);
    endfunction

    function automatic logic [TW-1:0] pix(int col, int r);
        return {samp(0, col, r), samp(1, col, r), samp(2, col, r), 8'hA5};
    endfunction

    // Channel-0 samples of a window as {oldest, middle, newest}.
    function automatic logic [23:0] ch0(logic [WIN_W-1:0] w);
        return {w[7:0], w[15:8], w[23:16]};
    endfunction

    // Reference: window k (image column, incl. flush columns) at row r takes image
    // column s = k-(BS-1-j) for slot j; outside [0,w) it is padding.
    task automatic gen(input int w, input int base, input bit mode);
        exp_t e;
        int   s;
        logic [7:0] v;
        for (int k = 0; k < w + NS; k++) begin
            for (int r = 0; r < H; r++) begin
                e.win = '0;
                for (int j = 0; j < BS; j++) begin
                    s = k - (BS - 1 - j);
                    for (int c = 0; c < CH; c++) begin
                        if (s < 0)       v = mode ? samp(c, base, r) : 8'h00;
                        else if (s >= w) v = mode ? samp(c, base + w - 1, r) : 8'h00;
                        else             v = samp(c, base + s, r);
                        e.win[(c*BS+j)*DW +: DW] = v;
                    end
                end
                e.row  = ROW_W'(r);
                e.full = (k >= BS - 1) && (k < w);
                e.last = (k == w + NS - 1) && (r == H - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    always @(negedge aclk) begin
        exp_t e;
        if (aresetn && m_valid && m_ready) begin
            dut_cnt++;
            got_win.push_back(m_window);
            got_full.push_back(m_full);
            got_last.push_back(m_last);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_window: got window %0h row %0d, expected none", m_window, m_row);
            end else begin
                e = exp_q.pop_front();
                check("window", m_window, e.win);
                check("row", WIN_W'(m_row), WIN_W'(e.row));
                check("full", WIN_W'(m_full), WIN_W'(e.full));
                check("last", WIN_W'(m_last), WIN_W'(e.last));
            end
        end
    end

    task automatic send_pixel(input logic [TW-1:0] d, input bit last, output int stalls);
        int n = 0;
        bit ok = 0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tlast  = last;
        while (!ok && n < 200) begin
            @(negedge aclk);
            ok = s_axis_tready;
            @(posedge aclk);
            #1;
            n++;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: pixel %0h not accepted after %0d cycles, expected acceptance", d, n);
        end
        stalls = n - 1;
    endtask

    task automatic send_image(input int w, input int base, input bit mode, input int err_row,
                              input int npix, output int first_stall);
        int idx = 0;
        int sl;
        bit last;
        first_stall = 0;
        pad_mode = mode;
        for (int col = 0; col < w; col++) begin
            for (int r = 0; r < H; r++) begin
                if (npix < 0 || idx < npix) begin
                    last = ((col == w - 1) && (r == H - 1)) || ((col == 0) && (r == err_row));
                    send_pixel(pix(base + col, r), last, sl);
                    if (idx == 0) begin
                        first_stall = sl;
                        pad_mode = !mode;
                    end
                end
                idx++;
            end
        end
        s_axis_tlast = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge aclk);
            n++;
        end
        repeat (4) @(posedge aclk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d windows outstanding, expected 0", name, exp_q.size());
        end
    endtask

    task automatic start_test();
        dut_cnt = 0;
        got_win.delete();
        got_full.delete();
        got_last.delete();
    endtask

    task automatic pin(input string name, input int idx, input logic [23:0] exp);
        if (idx >= got_win.size()) begin
            checks++;
            errors++;
            $display("FAIL %s: window %0d missing, expected ch0 %0h", name, idx, exp);
        end else begin
            check(name, WIN_W'(ch0(got_win[idx])), WIN_W'(exp));
        end
    endtask

    task automatic pin_flag(input string name, input int idx, input bit is_last, input logic exp);
        if (idx >= got_win.size()) begin
            checks++;
            errors++;
            $display("FAIL %s: window %0d missing, expected flag %0d", name, idx, exp);
        end else begin
            check(name, WIN_W'(is_last ? got_last[idx] : got_full[idx]), WIN_W'(exp));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_valid", WIN_W'(m_valid), WIN_W'(1'b0));
        check("rst_full", WIN_W'(m_full), WIN_W'(1'b0));
        check("rst_last", WIN_W'(m_last), WIN_W'(1'b0));
        check("rst_tlast_err", WIN_W'(tlast_err), WIN_W'(1'b0));
        check("rst_window", m_window, '0);
        check("rst_row", WIN_W'(m_row), '0);
        @(posedge aclk);
        #1 aresetn = 1'b1;

        // Zero-pad 4x4 image
        start_test();
        gen(4, 0, 1'b0);
        send_image(4, 0, 1'b0, -1, -1, st);
        s_axis_tvalid = 1'b0;
        wait_drain("zero");
        check("zero_count", WIN_W'(dut_cnt), WIN_W'(24));
        pin("zero_c0r0", 0, 24'h000000);
        pin("zero_c2r1", 9, 24'h011121);
        pin_flag("zero_c2r1_full", 9, 1'b0, 1'b1);
        pin("zero_flush2r3", 23, 24'h330000);
        pin_flag("zero_flush2r3_last", 23, 1'b1, 1'b1);

        // Replicate-pad 4x4 image (pad_mode input flips after the first pixel)
        start_test();
        gen(4, 0, 1'b1);
        send_image(4, 0, 1'b1, -1, -1, st);
        s_axis_tvalid = 1'b0;
        wait_drain("rep");
        check("rep_count", WIN_W'(dut_cnt), WIN_W'(24));
        pin("rep_c0r2", 2, 24'h020202);
        pin("rep_c1r2", 6, 24'h020212);
        pin("rep_flush1r3", 19, 24'h233333);
        pin("rep_flush2r3", 23, 24'h333333);

        // Output backpressure mid-column
        start_test();
        gen(4, 0, 1'b0);
        fork
            send_image(4, 0, 1'b0, -1, -1, st);
            begin
                repeat (6) @(posedge aclk);
                #1 m_ready = 1'b0;
                @(negedge aclk);
                h_win = m_window;
                h_row = m_row;
                check("hold_valid", WIN_W'(m_valid), WIN_W'(1'b1));
                check("hold_tready", WIN_W'(s_axis_tready), WIN_W'(1'b0));
                repeat (4) begin
                    @(negedge aclk);
                    check("hold_valid", WIN_W'(m_valid), WIN_W'(1'b1));
                    check("hold_window", m_window, h_win);
                    check("hold_row", WIN_W'(m_row), WIN_W'(h_row));
                    check("hold_tready", WIN_W'(s_axis_tready), WIN_W'(1'b0));
                end
                @(posedge aclk);
                #1 m_ready = 1'b1;
            end
        join
        s_axis_tvalid = 1'b0;
        wait_drain("bp");
        check("bp_count", WIN_W'(dut_cnt), WIN_W'(24));

        // Back-to-back images with tvalid held through the flush; second image is narrow
        start_test();
        gen(4, 0, 1'b0);
        gen(1, 5, 1'b0);
        send_image(4, 0, 1'b0, -1, -1, st);
        send_image(1, 5, 1'b0, -1, -1, st2);
        s_axis_tvalid = 1'b0;
        check("flush_stall", WIN_W'(st2), WIN_W'(8));
        wait_drain("b2b");
        check("b2b_count", WIN_W'(dut_cnt), WIN_W'(36));
        pin("b2b_next_first", 24, 24'h000050);

        // Narrow replicate image
        start_test();
        gen(1, 7, 1'b1);
        send_image(1, 7, 1'b1, -1, -1, st);
        s_axis_tvalid = 1'b0;
        wait_drain("narrow");
        check("narrow_count", WIN_W'(dut_cnt), WIN_W'(12));
        pin("narrow_final", 11, 24'h737373);
        pin_flag("narrow_final_last", 11, 1'b1, 1'b1);

        // Early tlast on column 0 row 1
        start_test();
        gen(4, 0, 1'b0);
        send_image(4, 0, 1'b0, 1, -1, st);
        s_axis_tvalid = 1'b0;
        check("tlast_err_set", WIN_W'(tlast_err), WIN_W'(1'b1));
        wait_drain("tlast");
        check("tlast_err_sticky", WIN_W'(tlast_err), WIN_W'(1'b1));
        check("tlast_count", WIN_W'(dut_cnt), WIN_W'(24));

        // Reset mid-column 2
        start_test();
        gen(4, 0, 1'b0);
        send_image(4, 0, 1'b0, -1, 10, st);
        s_axis_tvalid = 1'b0;
        check("pre_rst_valid", WIN_W'(m_valid), WIN_W'(1'b1));
        aresetn = 1'b0;
        #1;
        check("midrst_valid", WIN_W'(m_valid), WIN_W'(1'b0));
        check("midrst_tlast_err", WIN_W'(tlast_err), WIN_W'(1'b0));
        exp_q.delete();
        repeat (2) @(posedge aclk);
        #1 aresetn = 1'b1;
        start_test();
        gen(4, 3, 1'b0);
        send_image(4, 3, 1'b0, -1, -1, st);
        s_axis_tvalid = 1'b0;
        wait_drain("post_rst");
        check("post_rst_count", WIN_W'(dut_cnt), WIN_W'(24));
        pin("post_rst_first", 0, 24'h000030);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stripe_window_buffer.md
Name: stripe_window_buffer

Overview:
- Parametrised successor to the column-stripe input buffer.
- Accepts a column-major pixel stream on AXI-Stream (IMAGE_HEIGHT pixels per column, top to bottom; tlast on the last pixel of the image).
- Emits one BLOCK_SIZE-wide horizontal window per row over a valid/ready output, for the processing block.
- Adds generic channel count, circular column storage instead of a full shift, selectable zero/replicate edge padding, and automatic right-edge flush.

Parameters:
DATA_WIDTH, 8, bits per channel sample
CHANNELS, 3, samples per pixel; channel 0 = R
BLOCK_SIZE, 3, window width in columns (>=2)
C_AXIS_TDATA_WIDTH, 32, stream width; CHANNELS*DATA_WIDTH <= C_AXIS_TDATA_WIDTH
IMAGE_HEIGHT, 480, rows per column (>=2)

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
s_axis_tvalid  in  1  input pixel valid
s_axis_tready  out  1  input pixel ready
s_axis_tdata  in  C_AXIS_TDATA_WIDTH  pixel; channel c = tdata[C_AXIS_TDATA_WIDTH-1-c*DATA_WIDTH -: DATA_WIDTH]
s_axis_tstrb  in  C_AXIS_TDATA_WIDTH/8  ignored
s_axis_tlast  in  1  last pixel of image
pad_mode  in  1  0 = zero pad, 1 = replicate edge column
m_valid  out  1  window valid
m_ready  in  1  window accepted
m_window  out  CHANNELS*BLOCK_SIZE*DATA_WIDTH  sample (c,j) at offset (c*BLOCK_SIZE+j)*DATA_WIDTH; j=0 oldest/leftmost, j=BLOCK_SIZE-1 newest
m_row  out  clog2(IMAGE_HEIGHT)  row index of window
m_full  out  1  all BLOCK_SIZE columns are real image data (no padding)
m_last  out  1  final window of image
tlast_err  out  1  sticky: tlast seen at row != IMAGE_HEIGHT-1

Behaviour:
- Reset is asynchronous and active-low. All outputs, counters, state and tlast_err go to 0. State goes to FILL. Storage contents are don't-care.
- Storage: BLOCK_SIZE-1 previous columns x IMAGE_HEIGHT x CHANNELS, in a circular slot array. wr_slot wraps modulo BLOCK_SIZE-1. There is no data shifting.
- Counters:
  - row: 0..IMAGE_HEIGHT-1, wraps.
  - col_sat: number of columns produced this image, saturating at BLOCK_SIZE-1.
  - flush_cnt: 0..BLOCK_SIZE-1.
- Output stage: a single register. It loads when (!m_valid || m_ready) and a new window is produced. m_valid stays asserted and m_window/m_row/m_full/m_last stay stable until m_ready.
- States:
  - FILL: s_axis_tready = !m_valid || m_ready.
    - On accept: build the window. Newest column = tdata samples; older columns come from storage at the same row. Write the tdata samples to storage[wr_slot][row]. Load the output register (latency 1 cycle). row++.
    - At row IMAGE_HEIGHT-1: row wraps to 0, wr_slot advances, col_sat increments.
    - If accepted with tlast at row IMAGE_HEIGHT-1, go to FLUSH.
  - FLUSH: s_axis_tready = 0.
    - Each cycle the output register is free, emit a window whose newest column is the pad value. Write that pad value to storage like a real column.
    - Pad value: 0 in zero mode; newest stored column at the same row in replicate mode.
    - Emits exactly (BLOCK_SIZE-1)*IMAGE_HEIGHT windows.
    - m_last = 1 on the final window (flush_cnt = BLOCK_SIZE-1, row = IMAGE_HEIGHT-1).
    - After that window loads: col_sat=0, row=0, wr_slot=0, go to FILL.
- Left padding: window column j is missing when j < BLOCK_SIZE-1-col_sat. A missing column is 0 in zero mode. In replicate mode it is column 0 of the same row: the current tdata when col_sat=0, otherwise the column-0 slot.
- pad_mode is latched on acceptance of row 0 of column 0 and held until the image ends, including flush.
- m_full = 1 iff col_sat = BLOCK_SIZE-1 and the state is FILL.
- tlast at row != IMAGE_HEIGHT-1: set tlast_err; framing continues unchanged (tlast ignored).
- tvalid while in FLUSH: held off by tready=0, no loss.
- Narrow images (fewer than BLOCK_SIZE-1 columns) are legal; both edges are padded.
- Reset mid-image: abandons the image; the next accepted pixel is column 0, row 0.

Test Plan:
- BLOCK_SIZE=3, IMAGE_HEIGHT=4, CHANNELS=3, zero mode, 4x4 image, pixel = col*16+row in all channels, m_ready=1:
  - 24 windows emitted.
  - (col0,row0) window = {0,0,0x00}.
  - (col2,row1) window = {0x01,0x11,0x21} with m_full=1.
  - Flush col 2 row 3 window = {0x33,0,0} with m_last=1.
- Same image, replicate mode:
  - (col0,row2) window = {0x02,0x02,0x02}.
  - (col1,row2) window = {0x02,0x02,0x12}.
  - Flush windows for row 3 = {0x23,0x33,0x33}, then {0x33,0x33,0x33}.
- Drop m_ready for 5 cycles mid-column: m_valid, m_window and m_row held; s_axis_tready=0; after release no pixel is lost or duplicated (24 windows total).
- With tlast on pixel 16 and tvalid held high: s_axis_tready=0 for exactly 8 window loads; the next image's first window is {0,0,p}.
- Assert aresetn low mid-column 2: m_valid=0 and tlast_err=0 immediately; after release the next pixel yields a left-padded col0 window.
- tlast on row 1 of column 0: tlast_err=1 and stays set; the stream continues and the image completes normally on the row-3 tlast.
